glyph_rom_sched: RTL and testbench

Burst scheduler and round-robin arbiter for the shared 64-row x 64-bit glyph/grid pattern ROM in the Basys3 oscilloscope display path. Up to NREQ overlay requesters (grid, trigger marker, channel labels, cursor readout) post row-burst requests. The block grants one requester at a time, walks the ROM address through the burst, and returns one registered 64-bit row per cycle tagged with the requester ID. It sits between the overlay generators and the combinational pattern ROM, which it owns exclusively.

---
 rtl/glyph_rom_sched_if.sv | 26 ++
 rtl/glyph_rom_sched.sv | 164 ++++++++++++++++
 tb/tb_glyph_rom_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/glyph_rom_sched_if.sv
// rtl/glyph_rom_sched_if.sv - requester and row-return bus between overlay generators and the glyph ROM scheduler
interface glyph_rom_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 6,
  parameter int DW   = 64
);
  logic [NREQ-1:0]    req;
  logic [AW*NREQ-1:0] req_addr;
  logic [AW*NREQ-1:0] req_len;
  logic [NREQ-1:0]    gnt;
  logic               rvalid;
  logic [DW-1:0]      rdata;
  logic [IDW-1:0]     rid;
  logic               rlast;

  modport master (
    output req, req_addr, req_len,
    input  gnt, rvalid, rdata, rid, rlast
  );

  modport slave (
    input  req, req_addr, req_len,
    output gnt, rvalid, rdata, rid, rlast
  );
endinterface

// File: rtl/glyph_rom_sched.sv
// rtl/glyph_rom_sched.sv - burst scheduler and arbiter owning the shared 64x64 glyph/grid pattern ROM
// Define GLYPH_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration (default is round-robin).
module glyph_rom_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 6,
  parameter int DW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  glyph_rom_sched_if.slave bus,
  input  logic            flush,
  output logic            busy,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data
);
  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  cnt;
  logic [IDW-1:0] cur_id;
  logic           found;
  logic [IDW-1:0] win;
  logic [AW-1:0]  sel_addr, sel_len;
  logic           arb;

  logic [NREQ-1:0] gnt_d;
  logic            busy_d, rvalid_d, rlast_d;
  logic [AW-1:0]   addr_d, cnt_d;
  logic [IDW-1:0]  id_d, rid_d;
  logic [DW-1:0]   rdata_d;

`ifdef GLYPH_SCHED_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr;

  // Two passes: indices at/after the pointer first, then wrap to the low ones.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (arb) begin
      ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end
`endif

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_addr = bus.req_addr[AW*i +: AW];
        sel_len  = bus.req_len[AW*i +: AW];
      end
    end
  end

  assign arb = (state == S_IDLE) && found && !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arb) state_nxt = S_BURST;
      S_BURST: if (flush || cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = '0;
    busy_d   = busy;
    addr_d   = rom_addr;
    cnt_d    = cnt;
    id_d     = cur_id;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    rdata_d  = bus.rdata;
    rid_d    = bus.rid;
    case (state)
      S_IDLE: begin
        if (arb) begin
          gnt_d  = NREQ'(1) << win;
          busy_d = 1'b1;
          addr_d = sel_addr;
          cnt_d  = sel_len;
          id_d   = win;
        end
      end
      S_BURST: begin
        if (flush) begin
          busy_d = 1'b0;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = rom_data;
          rid_d    = cur_id;
          rlast_d  = (cnt == '0);
          if (cnt == '0) begin
            busy_d = 1'b0;
          end else begin
            addr_d = rom_addr + 1'b1;
            cnt_d  = cnt - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt    <= '0;
      busy       <= 1'b0;
      rom_addr   <= '0;
      cnt        <= '0;
      cur_id     <= '0;
      bus.rvalid <= 1'b0;
      bus.rlast  <= 1'b0;
      bus.rdata  <= '0;
      bus.rid    <= '0;
    end else begin
      bus.gnt    <= gnt_d;
      busy       <= busy_d;
      rom_addr   <= addr_d;
      cnt        <= cnt_d;
      cur_id     <= id_d;
      bus.rvalid <= rvalid_d;
      bus.rlast  <= rlast_d;
      bus.rdata  <= rdata_d;
      bus.rid    <= rid_d;
    end
  end
endmodule

// File: tb/tb_glyph_rom_sched.sv
// tb/tb_glyph_rom_sched.sv - directed self-checking bench for glyph_rom_sched
module tb_glyph_rom_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        busy;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;

  int checks = 0;
  int passes = 0;

  glyph_rom_sched_if #(.NREQ(4), .IDW(2), .AW(6), .DW(64)) bus ();

  glyph_rom_sched #(.NREQ(4), .IDW(2), .AW(6), .DW(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_row(input logic [5:0] a);
    return {8{2'b10, a}};
  endfunction

  assign rom_data = rom_row(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.req = '0; bus.req_addr = '0; bus.req_len = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", bus.gnt); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (rom_addr !== 6'd0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else passes++;
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL reset_rvalid got %b want 0", bus.rvalid); else passes++;
    checks++; if (bus.rdata !== 64'd0) $display("FAIL reset_rdata got %h want 0", bus.rdata); else passes++;
    checks++; if (bus.rid !== 2'd0 || bus.rlast !== 1'b0) $display("FAIL reset_rid_rlast got %0d/%b want 0/0", bus.rid, bus.rlast); else passes++;
  endtask

  task automatic test_basic();
    logic [5:0] exp_a;
    bus.req = 4'b0001;
    bus.req_addr = {6'd0, 6'd0, 6'd0, 6'd10};
    bus.req_len  = {6'd0, 6'd0, 6'd0, 6'd2};
    tick();
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL basic_gnt got %b want 0001", bus.gnt); else passes++;
    checks++; if (busy !== 1'b1 || rom_addr !== 6'd10) $display("FAIL basic_busy_addr got %b/%0d want 1/10", busy, rom_addr); else passes++;
    bus.req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_a = 6'(10 + k);
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== rom_row(exp_a) || bus.rid !== 2'd0)
        $display("FAIL basic_beat%0d got v=%b d=%h id=%0d want v=1 d=%h id=0", k, bus.rvalid, bus.rdata, bus.rid, rom_row(exp_a));
      else passes++;
      checks++; if (bus.rlast !== (k == 2)) $display("FAIL basic_rlast%0d got %b want %b", k, bus.rlast, k == 2); else passes++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall got %b want 0", busy); else passes++;
    tick();
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL basic_after got rvalid %b want 0", bus.rvalid); else passes++;
  endtask

  task automatic test_wrap();
    logic [5:0] exp_rows [4];
    exp_rows = '{6'd62, 6'd63, 6'd0, 6'd1};
    bus.req = 4'b0001;
    bus.req_addr = {6'd0, 6'd0, 6'd0, 6'd62};
    bus.req_len  = {6'd0, 6'd0, 6'd0, 6'd3};
    tick();
    checks++; if (bus.gnt !== 4'b0001 || rom_addr !== 6'd62) $display("FAIL wrap_gnt got %b/%0d want 0001/62", bus.gnt, rom_addr); else passes++;
    bus.req = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== rom_row(exp_rows[k]) || bus.rlast !== (k == 3))
        $display("FAIL wrap_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", k, bus.rvalid, bus.rdata, bus.rlast, rom_row(exp_rows[k]), k == 3);
      else passes++;
    end
    tick();
  endtask

  task automatic test_round_robin();
    int order [5];
`ifdef GLYPH_SCHED_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 4'b1111;
    bus.req_addr = {6'd23, 6'd22, 6'd21, 6'd20};
    bus.req_len  = '0;
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 4 && bus.gnt === 4'b0000; n++) tick();
      checks++; if (bus.gnt !== (4'b0001 << order[k])) $display("FAIL rr_gnt%0d got %b want %b", k, bus.gnt, 4'b0001 << order[k]); else passes++;
      checks++; if (bus.rvalid !== 1'b0) $display("FAIL rr_gap%0d got rvalid %b want 0", k, bus.rvalid); else passes++;
      if (k == 4) bus.req = '0;
      tick();
      checks++; if (bus.rvalid !== 1'b1 || bus.rid !== 2'(order[k]) || bus.rlast !== 1'b1 || bus.rdata !== rom_row(6'(20 + order[k])))
        $display("FAIL rr_beat%0d got v=%b id=%0d l=%b d=%h want v=1 id=%0d l=1 d=%h", k, bus.rvalid, bus.rid, bus.rlast, bus.rdata, order[k], rom_row(6'(20 + order[k])));
      else passes++;
    end
    tick();
  endtask

  task automatic test_flush();
    int beats = 0;
    bus.req = 4'b0001;
    bus.req_addr = {6'd0, 6'd0, 6'd40, 6'd5};
    bus.req_len  = {6'd0, 6'd0, 6'd1, 6'd5};
    tick();
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL flush_gnt0 got %b want 0001", bus.gnt); else passes++;
    bus.req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.rvalid === 1'b1) beats++;
      checks++; if (bus.rdata !== rom_row(6'(5 + k)) || bus.rlast !== 1'b0)
        $display("FAIL flush_beat%0d got d=%h l=%b want d=%h l=0", k, bus.rdata, bus.rlast, rom_row(6'(5 + k)));
      else passes++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (beats !== 3) $display("FAIL flush_beats got %0d want 3", beats); else passes++;
    checks++; if (bus.rvalid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_stop got v=%b busy=%b want 0/0", bus.rvalid, busy); else passes++;
    tick();
    checks++; if (bus.gnt !== 4'b0010 || rom_addr !== 6'd40) $display("FAIL flush_next_gnt got %b/%0d want 0010/40", bus.gnt, rom_addr); else passes++;
    bus.req = '0;
    tick();
    checks++; if (bus.rid !== 2'd1 || bus.rdata !== rom_row(6'd40) || bus.rlast !== 1'b0) $display("FAIL flush_req1_b0 got id=%0d d=%h l=%b", bus.rid, bus.rdata, bus.rlast); else passes++;
    tick();
    checks++; if (bus.rdata !== rom_row(6'd41) || bus.rlast !== 1'b1) $display("FAIL flush_req1_b1 got d=%h l=%b want d=%h l=1", bus.rdata, bus.rlast, rom_row(6'd41)); else passes++;
    tick();
  endtask

  task automatic test_flush_idle();
    logic [3:0] exp_g;
`ifdef GLYPH_SCHED_FIXED_PRIO_EN
    exp_g = 4'b0010;
`else
    exp_g = 4'b1000;
`endif
    bus.req = 4'b1010;
    bus.req_addr = '0;
    bus.req_len  = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bus.gnt !== 4'b0000 || busy !== 1'b0) $display("FAIL flush_idle got gnt=%b busy=%b want 0000/0", bus.gnt, busy); else passes++;
    tick();
    checks++; if (bus.gnt !== exp_g) $display("FAIL flush_idle_ptr got %b want %b", bus.gnt, exp_g); else passes++;
    bus.req = '0;
    tick(); tick();
  endtask

  task automatic test_ignore_changes();
    bus.req = 4'b0100;
    bus.req_addr = {6'd0, 6'd30, 6'd0, 6'd0};
    bus.req_len  = {6'd0, 6'd2, 6'd0, 6'd0};
    tick();
    checks++; if (bus.gnt !== 4'b0100) $display("FAIL ign_gnt got %b want 0100", bus.gnt); else passes++;
    bus.req = '0;
    bus.req_addr = {6'd0, 6'd50, 6'd0, 6'd0};
    bus.req_len  = {6'd0, 6'd7, 6'd0, 6'd0};
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rvalid !== 1'b1 || bus.rid !== 2'd2 || bus.rdata !== rom_row(6'(30 + k)) || bus.rlast !== (k == 2))
        $display("FAIL ign_beat%0d got v=%b id=%0d d=%h l=%b want v=1 id=2 d=%h l=%b", k, bus.rvalid, bus.rid, bus.rdata, bus.rlast, rom_row(6'(30 + k)), k == 2);
      else passes++;
    end
    tick();
    checks++; if (bus.rvalid !== 1'b0 || busy !== 1'b0) $display("FAIL ign_end got v=%b busy=%b want 0/0", bus.rvalid, busy); else passes++;
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0001;
    bus.req_addr = {6'd0, 6'd0, 6'd0, 6'd8};
    bus.req_len  = {6'd0, 6'd0, 6'd0, 6'd10};
    tick();
    bus.req = '0;
    tick(); tick();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.req_len = '0;
    tick();
    rst = 1'b0;
    checks++; if (bus.rvalid !== 1'b0 || busy !== 1'b0 || rom_addr !== 6'd0)
      $display("FAIL rstmid got v=%b busy=%b addr=%0d want 0/0/0", bus.rvalid, busy, rom_addr);
    else passes++;
    tick();
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL rstmid_gnt got %b want 0001", bus.gnt); else passes++;
    bus.req = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_round_robin();
    test_flush();
    test_flush_idle();
    test_ignore_changes();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
